pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline buffers.
- Resolves three conditions: load-use hazards, taken branches, and multi-cycle data-memory waits.
- Holds a memory-wait FSM with a timeout watchdog, plus a stall-cycle performance counter.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 32, stall counter width.
- TIMEOUT, 64, maximum MEM_WAIT cycles before mem_err is raised.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  REG_W  source register rs of the instruction in ID.
- id_rt  in  REG_W  source register rt of the instruction in ID.
- id_rt_used  in  1  ID instruction reads rt.
- ex_MemRead  in  1  instruction in EX is a load.
- ex_write_reg  in  REG_W  destination register of the instruction in EX.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  MEM stage holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear to NOP.
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX clear (control bits zero).
- exmem_en  out  1  EX/MEM load enable.
- memwb_bubble  out  1  forces RegWrite_in=0 and MemtoReg_in=0 into the MEM/WB buffer.
- mem_err  out  1  sticky timeout flag.
- stall_count  out  CNT_W  cycles with pc_en=0.

Behaviour:
- Asynchronous reset (reset=0):
  - state=RUN, wait_cnt=0, mem_err=0, stall_count=0.
  - While reset is held: all *_en=0, all flushes=0, memwb_bubble=1.
- Control outputs are combinational from the registered state and the current inputs, so they act in the same cycle. mem_err and stall_count are registered.
- Load-use hazard (luh):
  - luh = ex_MemRead & (ex_write_reg != 0) & ((ex_write_reg == id_rs) | (id_rt_used & ex_write_reg == id_rt)).
- FSM state RUN, evaluated in priority order:
  1. mem_req & !mem_ready: go to MEM_WAIT this cycle. Outputs: pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1, flushes=0. branch_taken and luh are ignored; EX is frozen, so they are re-evaluated after the wait.
  2. else branch_taken: ifid_flush=1, idex_flush=1, all enables=1, memwb_bubble=0. The branch takes priority over luh.
  3. else luh: pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1. This inserts exactly one bubble; the next cycle has luh=0 because the load has moved to MEM.
  4. else: all enables=1, flushes=0, memwb_bubble=0.
- FSM state MEM_WAIT:
  - Outputs are frozen exactly as in RUN case 1.
  - wait_cnt increments each cycle.
  - On mem_ready=1: outputs are RUN case 4 (the access retires this cycle), state goes to RUN next edge, and wait_cnt clears.
  - When wait_cnt reaches TIMEOUT-1 without mem_ready: mem_err is set to 1 (sticky until reset). The FSM stays in MEM_WAIT and wait_cnt saturates.
  - mem_req dropping while in MEM_WAIT is treated as mem_ready (abort) and returns to RUN.
- stall_count increments on every non-reset cycle with pc_en=0 and saturates at all-ones.
- Reset asserted mid-MEM_WAIT: immediate return to RUN with counters cleared; mem_err clears.

Test Plan:
1. Load-use: ex_MemRead=1, ex_write_reg=5, id_rs=5, no mem/branch -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle (ex_MemRead=0) all enables=1; stall_count=1.
2. $zero and rt gating: ex_write_reg=0, id_rs=0 -> no stall. Then ex_write_reg=7, id_rt=7, id_rt_used=0 -> no stall; with id_rt_used=1 -> stall.
3. Branch vs load-use, same cycle: branch_taken=1 with luh=1 -> ifid_flush=1, idex_flush=1, pc_en=1; stall_count unchanged.
4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> pc_en/ifid_en/idex_en/exmem_en=0 and memwb_bubble=1 for 3 cycles; in the 4th cycle all enables=1; state returns to RUN; stall_count=3. A branch_taken pulse during the wait causes no flush.
5. Timeout: TIMEOUT=4, mem_req=1, mem_ready held 0 -> mem_err rises after the 4th wait cycle and stays 1 after mem_ready returns; it clears only on reset=0.
6. Asynchronous reset mid-wait: drop reset between clock edges during MEM_WAIT -> outputs go to reset values immediately (memwb_bubble=1, enables=0); after release, the first cycle with no hazard shows all enables=1 and stall_count=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard inputs from the pipeline and buffer controls back to it.
// The pipeline side uses master; the controller uses slave.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rt_used;
  logic             ex_MemRead;
  logic [REG_W-1:0] ex_write_reg;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_rt_used, ex_MemRead, ex_write_reg,
           branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_bubble, mem_err, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_rt_used, ex_MemRead, ex_write_reg,
           branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_bubble, mem_err, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch and data-memory wait,
// with a memory timeout watchdog and a stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int WC_W = $clog2(TIMEOUT) + 1;
  localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(TIMEOUT - 1);
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  // Control vector: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}
  localparam logic [6:0] CTL_NORM   = 7'b1101010;
  localparam logic [6:0] CTL_LUH    = 7'b0001110;
  localparam logic [6:0] CTL_BRANCH = 7'b1111110;
  localparam logic [6:0] CTL_FREEZE = 7'b0000001;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state;
  logic [WC_W-1:0]  wait_cnt;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_q;
  logic             luh, mem_stall;
  logic [6:0]       ctl;

  assign luh = bus.ex_MemRead & (bus.ex_write_reg != ZERO_REG) &
               ((bus.ex_write_reg == bus.id_rs) |
                (bus.id_rt_used & (bus.ex_write_reg == bus.id_rt)));

  // Dropping mem_req mid-wait counts as completion, so one term covers both states.
  assign mem_stall = bus.mem_req & ~bus.mem_ready;

  always_comb begin
    ctl = CTL_NORM;
    if (!reset)
      ctl = CTL_FREEZE;
    else if (mem_stall)
      ctl = CTL_FREEZE;
    else if (state == RUN) begin
      if (bus.branch_taken)
        ctl = CTL_BRANCH;
      else if (luh)
        ctl = CTL_LUH;
    end
  end

  assign {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
          bus.idex_flush, bus.exmem_en, bus.memwb_bubble} = ctl;
  assign bus.mem_err     = mem_err_q;
  assign bus.stall_count = stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      if (mem_stall) begin
        state <= MEM_WAIT;
        // Watchdog: the first stalled cycle is wait 1, so the flag rises after TIMEOUT waits.
        if (wait_cnt == WC_MAX)
          mem_err_q <= 1'b1;
        else
          wait_cnt <= wait_cnt + 1'b1;
      end else begin
        state    <= RUN;
        wait_cnt <= '0;
      end
      if (!ctl[6] && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a table of single-cycle RUN vectors,
// then hand-written sequences for memory wait, timeout and reset mid-wait.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 4;

  localparam logic [6:0] NORM = 7'b1101010;
  localparam logic [6:0] LUH  = 7'b0001110;
  localparam logic [6:0] BR   = 7'b1111110;
  localparam logic [6:0] FRZ  = 7'b0000001;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   exp_stall;

  pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       rt_used, mem_read;
    logic [4:0] wr;
    logic       br, mreq, mrdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [6:0] ctl();
    return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
            bus.idex_flush, bus.exmem_en, bus.memwb_bubble};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic rt_used,
                       input logic mem_read, input logic [4:0] wr, input logic br,
                       input logic mreq, input logic mrdy);
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rt_used   = rt_used;
    bus.ex_MemRead   = mem_read;
    bus.ex_write_reg = wr;
    bus.branch_taken = br;
    bus.mem_req      = mreq;
    bus.mem_ready    = mrdy;
  endtask

  // Apply one cycle of inputs at the falling edge; checks follow #1 later.
  task automatic cyc(input logic br, input logic mreq, input logic mrdy);
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, br, mreq, mrdy);
    #1;
  endtask

  initial begin
    //          name          rs  rt  rtu mr  wr  br mq mr  exp
    vecs[0]  = '{"idle",       0,  0, 0,  0,  0,  0, 0, 0, NORM};
    vecs[1]  = '{"luh_rs",     5,  0, 0,  1,  5,  0, 0, 0, LUH};
    vecs[2]  = '{"luh_after",  5,  0, 0,  0,  5,  0, 0, 0, NORM};
    vecs[3]  = '{"zero_reg",   0,  0, 0,  1,  0,  0, 0, 0, NORM};
    vecs[4]  = '{"rt_unused",  3,  7, 0,  1,  7,  0, 0, 0, NORM};
    vecs[5]  = '{"rt_used",    3,  7, 1,  1,  7,  0, 0, 0, LUH};
    vecs[6]  = '{"br_vs_luh",  5,  0, 0,  1,  5,  1, 0, 0, BR};
    vecs[7]  = '{"br_only",    1,  2, 1,  0,  9,  1, 0, 0, BR};
    vecs[8]  = '{"no_load",    9,  9, 1,  0,  9,  0, 0, 0, NORM};
    vecs[9]  = '{"luh_both",  12, 12, 1,  1, 12,  0, 0, 0, LUH};
    vecs[10] = '{"mem_hit",    0,  0, 0,  0,  0,  0, 1, 1, NORM};

    reset = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    check("reset_ctl",   64'(ctl()), 64'(FRZ));
    check("reset_stall", 64'(bus.stall_count), 64'd0);
    check("reset_err",   64'(bus.mem_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    exp_stall = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rs, vecs[i].rt, vecs[i].rt_used, vecs[i].mem_read,
            vecs[i].wr, vecs[i].br, vecs[i].mreq, vecs[i].mrdy);
      #1;
      check(vecs[i].name, 64'(ctl()), 64'(vecs[i].exp));
      if (!vecs[i].exp[6]) exp_stall++;
    end
    cyc(0, 0, 0);
    check("table_stall_count", 64'(bus.stall_count), 64'(exp_stall));

    // Memory wait of 3 cycles; branch pulse mid-wait must not flush.
    cyc(0, 1, 0); check("wait1", 64'(ctl()), 64'(FRZ));
    cyc(1, 1, 0); check("wait2_branch", 64'(ctl()), 64'(FRZ));
    cyc(0, 1, 0); check("wait3", 64'(ctl()), 64'(FRZ));
    cyc(0, 1, 1); check("wait_retire", 64'(ctl()), 64'(NORM));
    cyc(1, 0, 0); check("wait_back_run", 64'(ctl()), 64'(BR));
    exp_stall += 3;
    check("wait_stall_count", 64'(bus.stall_count), 64'(exp_stall));
    check("wait_no_err", 64'(bus.mem_err), 64'd0);

    // Timeout: flag rises only after the 4th stalled cycle, then stays.
    cyc(0, 1, 0); check("to_wait1", 64'(ctl()), 64'(FRZ));
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0); check("to_err_before", 64'(bus.mem_err), 64'd0);
    cyc(0, 1, 0); check("to_err_rise", 64'(bus.mem_err), 64'd1);
    check("to_still_frozen", 64'(ctl()), 64'(FRZ));
    cyc(0, 1, 1); check("to_retire", 64'(ctl()), 64'(NORM));
    cyc(0, 0, 0); check("to_err_sticky", 64'(bus.mem_err), 64'd1);
    exp_stall += 5;
    check("to_stall_count", 64'(bus.stall_count), 64'(exp_stall));
    #2;
    reset = 1'b0;
    #1;
    check("to_err_reset", 64'(bus.mem_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset between edges while in MEM_WAIT.
    cyc(0, 1, 0);
    cyc(0, 1, 0); check("rst_wait", 64'(ctl()), 64'(FRZ));
    #1;
    reset = 1'b0;
    #1;
    check("rst_async_ctl",   64'(ctl()), 64'(FRZ));
    check("rst_async_stall", 64'(bus.stall_count), 64'd0);
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_run_branch", 64'(ctl()), 64'(BR));
    cyc(0, 0, 0);
    check("rst_first_norm", 64'(ctl()), 64'(NORM));
    check("rst_stall_zero", 64'(bus.stall_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
